// File: rtl/cover_loader.sv
// cover_loader: packs a big-endian byte stream into 16-bit words and fills the cover-art BRAM via port A.
// Optional build macro COVER_LOADER_CHECKSUM_EN adds o_checksum, the mod-2^16 sum of written words.
module cover_loader #(
    parameter int PIX_COUNT = 19200,
    parameter int ADDR_BASE = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic [14:0] o_addra,
    output logic [15:0] o_dina,
    output logic        o_wea,
    output logic        o_busy,
    output logic        o_done,
`ifdef COVER_LOADER_CHECKSUM_EN
    output logic [15:0] o_checksum,
`endif
    output logic        o_valid_img
);
    localparam logic [14:0] BASE = 15'(ADDR_BASE);
    localparam logic [15:0] LAST = 16'(PIX_COUNT - 1);

    typedef enum logic [1:0] {IDLE, RX_HI, RX_LO, WR} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  hi_byte;
    logic [15:0] word_cnt;
    logic        xfer;
    logic        last_word;
    logic        abort_hit;

    function automatic logic [15:0] pack_word(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

    assign last_word = (word_cnt == LAST);
    assign abort_hit = i_abort && (state != IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        o_byte_ready = 1'b0;
        o_busy       = 1'b0;
        xfer         = 1'b0;
        case (state)
            IDLE: ;
            RX_HI: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
                xfer         = i_byte_valid;
                if (xfer) state_nxt = RX_LO;
            end
            RX_LO: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
                xfer         = i_byte_valid;
                if (xfer) state_nxt = WR;
            end
            WR: begin
                o_busy    = 1'b1;
                state_nxt = last_word ? IDLE : RX_HI;
            end
            default: state_nxt = IDLE;
        endcase
        // A restart outranks an abort; an abort only matters once a load is running.
        if (i_start)        state_nxt = RX_HI;
        else if (abort_hit) state_nxt = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (state == RX_HI && xfer) hi_byte <= i_byte;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            word_cnt    <= '0;
            o_addra     <= BASE;
            o_dina      <= '0;
            o_wea       <= 1'b0;
            o_done      <= 1'b0;
            o_valid_img <= 1'b0;
        end else begin
            o_wea  <= 1'b0;
            o_done <= 1'b0;
            if (i_start) begin
                word_cnt    <= '0;
                o_addra     <= BASE;
                o_valid_img <= 1'b0;
            end else if (abort_hit) begin
                o_valid_img <= 1'b0;
            end else begin
                case (state)
                    RX_LO: begin
                        if (xfer) begin
                            o_dina <= pack_word(hi_byte, i_byte);
                            o_wea  <= 1'b1;
                        end
                    end
                    WR: begin
                        // The last word closes the image instead of advancing, so no write past the end.
                        if (last_word) begin
                            o_done      <= 1'b1;
                            o_valid_img <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + 16'd1;
                            o_addra  <= o_addra + 15'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef COVER_LOADER_CHECKSUM_EN
    function automatic logic [15:0] wrap_add(input logic [15:0] a, input logic [15:0] b);
        return a + b;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)              o_checksum <= '0;
        else if (i_start)       o_checksum <= '0;
        else if (state == WR)   o_checksum <= wrap_add(o_checksum, o_dina);
    end
`endif

endmodule

// File: tb/tb_cover_loader.sv
// Bench for cover_loader: two instances (base 0 / 4 words, base 100 / 3 words) checked against a word-list model.
module tb_cover_loader;
    localparam int PIX_A  = 4;
    localparam int BASE_A = 0;
    localparam int PIX_B  = 3;
    localparam int BASE_B = 100;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start[2];
    logic        abort[2];
    logic        bvalid[2];
    logic [7:0]  bdata[2];
    logic        ready[2];
    logic [14:0] addra[2];
    logic [15:0] dina[2];
    logic        wea[2];
    logic        busy[2];
    logic        done[2];
    logic        vimg[2];
`ifdef COVER_LOADER_CHECKSUM_EN
    logic [15:0] csum[2];
    logic [15:0] exp_sum;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [30:0] wr_q[2][$];
    logic [30:0] exp_q[2][$];
    int          wr_cyc[2][$];
    int          done_cnt[2];
    int          done_cyc[2];
    int          bad_addr[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cover_loader #(.PIX_COUNT(PIX_A), .ADDR_BASE(BASE_A)) u_a (
        .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_abort(abort[0]),
        .i_byte(bdata[0]), .i_byte_valid(bvalid[0]), .o_byte_ready(ready[0]),
        .o_addra(addra[0]), .o_dina(dina[0]), .o_wea(wea[0]), .o_busy(busy[0]),
        .o_done(done[0]),
`ifdef COVER_LOADER_CHECKSUM_EN
        .o_checksum(csum[0]),
`endif
        .o_valid_img(vimg[0])
    );

    cover_loader #(.PIX_COUNT(PIX_B), .ADDR_BASE(BASE_B)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_abort(abort[1]),
        .i_byte(bdata[1]), .i_byte_valid(bvalid[1]), .o_byte_ready(ready[1]),
        .o_addra(addra[1]), .o_dina(dina[1]), .o_wea(wea[1]), .o_busy(busy[1]),
        .o_done(done[1]),
`ifdef COVER_LOADER_CHECKSUM_EN
        .o_checksum(csum[1]),
`endif
        .o_valid_img(vimg[1])
    );

    // Port-A write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int lo;
            int hi;
            lo = (k == 0) ? BASE_A : BASE_B;
            hi = (k == 0) ? BASE_A + PIX_A - 1 : BASE_B + PIX_B - 1;
            if (wea[k]) begin
                wr_q[k].push_back({addra[k], dina[k]});
                wr_cyc[k].push_back(cyc);
                if (int'(addra[k]) < lo || int'(addra[k]) > hi) bad_addr[k]++;
            end
            if (done[k]) begin
                done_cnt[k]++;
                done_cyc[k] = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int k = 0; k < n; k++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic clear(input int idx);
        wr_q[idx].delete();
        exp_q[idx].delete();
        wr_cyc[idx].delete();
        done_cnt[idx] = 0;
        done_cyc[idx] = 0;
        bad_addr[idx] = 0;
    endtask

    // Model: byte pairs form big-endian words at consecutive addresses from base.
    task automatic expect_image(input int idx, input bq_t b, input int base);
        logic [15:0] w;
`ifdef COVER_LOADER_CHECKSUM_EN
        exp_sum = '0;
`endif
        for (int k = 0; k < b.size() / 2; k++) begin
            w = {b[2*k], b[2*k+1]};
            exp_q[idx].push_back({15'(base + k), w});
`ifdef COVER_LOADER_CHECKSUM_EN
            exp_sum = exp_sum + w;
`endif
        end
    endtask

    task automatic compare_writes(input int idx, input string tag);
        int n;
        check({tag, "_nwrites"}, 32'(wr_q[idx].size()), 32'(exp_q[idx].size()));
        n = (wr_q[idx].size() < exp_q[idx].size()) ? wr_q[idx].size() : exp_q[idx].size();
        for (int k = 0; k < n; k++)
            check($sformatf("%s_wr%0d", tag, k), 32'(wr_q[idx][k]), 32'(exp_q[idx][k]));
    endtask

    task automatic check_csum(input int idx, input string tag);
`ifdef COVER_LOADER_CHECKSUM_EN
        check({tag, "_csum"}, 32'(csum[idx]), 32'(exp_sum));
`endif
    endtask

    task automatic check_zero(input int idx, input string tag, input int base);
        check({tag, "_busy"},  32'(busy[idx]),  32'd0);
        check({tag, "_ready"}, 32'(ready[idx]), 32'd0);
        check({tag, "_wea"},   32'(wea[idx]),   32'd0);
        check({tag, "_done"},  32'(done[idx]),  32'd0);
        check({tag, "_vimg"},  32'(vimg[idx]),  32'd0);
        check({tag, "_dina"},  32'(dina[idx]),  32'd0);
        check({tag, "_addra"}, 32'(addra[idx]), 32'(base));
`ifdef COVER_LOADER_CHECKSUM_EN
        check({tag, "_csum0"}, 32'(csum[idx]),  32'd0);
`endif
    endtask

    task automatic pulse_start(input int idx);
        start[idx] = 1'b1;
        @(posedge clk); #1;
        start[idx] = 1'b0;
    endtask

    task automatic stream(input int idx, input bq_t b, input bit rnd, input string tag);
        int pos = 0;
        int budget = 0;
        while (pos < b.size() && budget < 500) begin
            bvalid[idx] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bdata[idx]  = bvalid[idx] ? b[pos] : 8'($urandom);
            if (bvalid[idx] && ready[idx]) pos++;
            @(posedge clk); #1;
            budget++;
        end
        bvalid[idx] = 1'b0;
        check({tag, "_stream_done"}, 32'(pos), 32'(b.size()));
    endtask

    task automatic wait_done(input int idx, input string tag);
        int t = 0;
        while (done_cnt[idx] == 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_done_cnt"}, 32'(done_cnt[idx]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t s1, s2, s3, s4, part;
        int  rdy_seen;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; abort[k] = 1'b0; bvalid[k] = 1'b0; bdata[k] = 8'h00;
        end
        s1 = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        clear(0); clear(1);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero(0, "rst_a", BASE_A);
        check_zero(1, "rst_b", BASE_B);
        rst = 1'b0;
        @(posedge clk); #1;

        // Fixed stream, valid held high
        clear(0); expect_image(0, s1, BASE_A);
        pulse_start(0);
        check("t1_busy", 32'(busy[0]), 32'd1);
        stream(0, s1, 1'b0, "t1");
        wait_done(0, "t1");
        compare_writes(0, "t1");
        for (int k = 1; k < wr_cyc[0].size(); k++)
            check($sformatf("t1_gap%0d", k), 32'(wr_cyc[0][k] - wr_cyc[0][k-1]), 32'd3);
        if (wr_cyc[0].size() > 0)
            check("t1_done_lat", 32'(done_cyc[0]), 32'(wr_cyc[0][wr_cyc[0].size()-1] + 1));
        check("t1_vimg", 32'(vimg[0]), 32'd1);
        check("t1_idle", 32'(busy[0]), 32'd0);
        check_csum(0, "t1");

        // Same stream, random valid
        clear(0); expect_image(0, s1, BASE_A);
        pulse_start(0);
        stream(0, s1, 1'b1, "t2");
        wait_done(0, "t2");
        compare_writes(0, "t2");
        check("t2_vimg", 32'(vimg[0]), 32'd1);
        check_csum(0, "t2");

        // Restart after two words; the restart lands on the second word's WR cycle
        clear(0);
        s2 = rand_bytes(8);
        part = s1[0:3];
        expect_image(0, part, BASE_A);
        expect_image(0, s2, BASE_A);
        pulse_start(0);
        stream(0, part, 1'b1, "t3a");
        check("t3_wea_in_wr", 32'(wea[0]), 32'd1);
        pulse_start(0);
        check("t3_vimg_cleared", 32'(vimg[0]), 32'd0);
        stream(0, s2[0:5], 1'b1, "t3b");
        check("t3_vimg_mid", 32'(vimg[0]), 32'd0);
        check("t3_no_done_mid", 32'(done_cnt[0]), 32'd0);
        stream(0, s2[6:7], 1'b1, "t3c");
        wait_done(0, "t3");
        compare_writes(0, "t3");
        check("t3_vimg", 32'(vimg[0]), 32'd1);
        check_csum(0, "t3");

        // Abort after the high byte
        clear(0);
        pulse_start(0);
        stream(0, s1[0:0], 1'b1, "t4");
        abort[0] = 1'b1;
        @(posedge clk); #1;
        abort[0] = 1'b0;
        check("t4_busy", 32'(busy[0]), 32'd0);
        check("t4_vimg", 32'(vimg[0]), 32'd0);
        rdy_seen = 0;
        bvalid[0] = 1'b1; bdata[0] = 8'hA5;
        repeat (5) begin
            if (ready[0]) rdy_seen++;
            @(posedge clk); #1;
        end
        bvalid[0] = 1'b0;
        check("t4_ready_cycles", 32'(rdy_seen), 32'd0);
        check("t4_nwrites", 32'(wr_q[0].size()), 32'd0);
        check("t4_done_cnt", 32'(done_cnt[0]), 32'd0);
        abort[0] = 1'b1;
        @(posedge clk); #1;
        abort[0] = 1'b0;
        check("t4_abort_idle_busy", 32'(busy[0]), 32'd0);

        // Non-zero base, three words
        clear(1);
        s3 = rand_bytes(6);
        expect_image(1, s3, BASE_B);
        pulse_start(1);
        check("t5_addra_start", 32'(addra[1]), 32'(BASE_B));
        stream(1, s3, 1'b1, "t5");
        wait_done(1, "t5");
        compare_writes(1, "t5");
        check("t5_vimg", 32'(vimg[1]), 32'd1);
        check_csum(1, "t5");
        bvalid[1] = 1'b1; bdata[1] = 8'h5A;
        repeat (4) @(posedge clk);
        #1;
        bvalid[1] = 1'b0;
        check("t5_nwrites_after", 32'(wr_q[1].size()), 32'd3);
        check("t5_bad_addr", 32'(bad_addr[1]), 32'd0);

        // Async reset between edges while in RX_LO of the second word
        clear(0);
        s4 = rand_bytes(8);
        pulse_start(0);
        stream(0, s4[0:2], 1'b0, "t6a");
        check("t6_addra_pre", 32'(addra[0]), 32'(BASE_A + 1));
        #2 rst = 1'b1;
        #1;
        check_zero(0, "t6_rst", BASE_A);
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        clear(0); expect_image(0, s4, BASE_A);
        pulse_start(0);
        stream(0, s4, 1'b1, "t6b");
        wait_done(0, "t6");
        compare_writes(0, "t6");
        check("t6_vimg", 32'(vimg[0]), 32'd1);
        check_csum(0, "t6");
        check("all_bad_addr_a", 32'(bad_addr[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
